// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared RAM port arbiter: fetch (i_*) and load/store (d_*)
// requester handshakes plus the single RAM port (mem_*).
// Ports: slave = arbiter view, master = CPU pipeline + RAM view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic [3:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between instruction
// fetch (I) and load/store (D); routes read data back after READ_LAT cycles.
// Ports: clk, rst (sync, active high), stall (blocks new grants),
//        bus (slave modport: requesters + RAM port), cpu_stall,
//        conflict_cnt (saturating count of contended, unstalled cycles).
module mem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    mem_port_arbiter_if.slave    bus,
    output logic                 cpu_stall,
    output logic [15:0]          conflict_cnt
);

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } last_gnt_e;

    last_gnt_e           last_gnt_q, last_gnt_d;
    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [READ_LAT-1:0] tag_q, tag_d;
    logic [15:0]         cnt_q, cnt_d;

    logic                gnt_i, gnt_d;
    logic [ADDR_W-1:0]   addr_mux;
    logic [DATA_W-1:0]   rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= LAST_I;
            vld_q      <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        gnt_i      = 1'b0;
        gnt_d      = 1'b0;
        last_gnt_d = last_gnt_q;
        vld_d      = '0;
        tag_d      = '0;
        cnt_d      = cnt_q;

        // Requests seen during reset are held off until reset drops.
        if (!rst && !stall) begin
            if (bus.i_req && bus.d_req) begin
                if (last_gnt_q == LAST_I) gnt_d = 1'b1;
                else                      gnt_i = 1'b1;
            end else if (bus.i_req) begin
                gnt_i = 1'b1;
            end else if (bus.d_req) begin
                gnt_d = 1'b1;
            end
        end

        if (gnt_i) last_gnt_d = LAST_I;
        if (gnt_d) last_gnt_d = LAST_D;

        // Stage 0 records this cycle's grant; tag 1 marks a D read.
        vld_d[0] = gnt_i | (gnt_d && bus.d_we == 4'b0000);
        tag_d[0] = gnt_d;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end

        if (bus.i_req && bus.d_req && !stall && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;

        addr_mux = gnt_d ? bus.d_addr : bus.i_addr;
        rdata    = bus.mem_rdata;

        bus.i_ack     = gnt_i;
        bus.d_ack     = gnt_d;
        bus.mem_en    = gnt_i | gnt_d;
        bus.mem_we    = gnt_d ? bus.d_we : 4'b0000;
        bus.mem_addr  = addr_mux;
        bus.mem_wdata = bus.d_wdata;

        // The last stage is only cleared at the reset edge, so mask it here.
        bus.i_rvalid  = !rst && vld_q[READ_LAT-1] && !tag_q[READ_LAT-1];
        bus.d_rvalid  = !rst && vld_q[READ_LAT-1] &&  tag_q[READ_LAT-1];
        bus.i_rdata   = rdata;
        bus.d_rdata   = rdata;

        cpu_stall    = (bus.i_req && !gnt_i) || (bus.d_req && !gnt_d);
        conflict_cnt = cnt_q;
    end

endmodule
